mux_arb_nto1: RTL

MUX_ARB_NTO1 -- requirements
Module: mux_arb_nto1

---
 rtl/mux_arb_pkg.sv | 17 +
 rtl/mux_arb_nto1_rr_pick.sv | 29 ++
 rtl/mux_arb_nto1.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the N-to-1 arbitrating multiplexer.
// Holds the mode encodings, lock FSM state type and default sizing.
// The optional channel-lock feature is enabled with macro MUX_ARB_LOCK_EN.
package mux_arb_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_N     = 4;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/mux_arb_nto1_rr_pick.sv
// Round-robin priority search: first requesting channel after ptr,
// wrapping modulo N. Purely combinational.
module rr_pick #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant_idx,
  output logic            any_valid
);

  int idx;

  // Walk channels ptr+1 .. ptr+N (mod N); the first hit wins.
  always_comb begin
    grant_idx = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any_valid && req[idx]) begin
        any_valid = 1'b1;
        grant_idx = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-to-1 arbitrating multiplexer with a one-word registered output slot.
// Explicit-select or round-robin arbitration; a grant is only issued when
// the output slot is free, so accepted words are never dropped.
// Define MUX_ARB_LOCK_EN to add in_lock and the IDLE/LOCKED channel-lock FSM.
//
// state     | meaning
// ST_IDLE   | normal arbitration by mode/sel
// ST_LOCKED | only the stored channel lock_idx_q may be granted
module mux_arb_nto1
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = DEFAULT_N,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
`ifdef MUX_ARB_LOCK_EN
  input  logic [N-1:0]         in_lock,
`endif
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_src
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_src_q, out_src_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic             slot_free;
  logic             sel_req;
  logic [SELW-1:0]  rr_idx;
  logic             rr_any;
  logic             cand_valid;
  logic [SELW-1:0]  cand_idx;
  logic [WIDTH-1:0] cand_data;
  logic             grant_valid;

  assign slot_free = !out_valid_q || out_ready;

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_pick (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .grant_idx (rr_idx),
    .any_valid (rr_any)
  );

  // Explicit-mode request: compare against legal indices only, so sel>=N never matches.
  always_comb begin
    sel_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i)) sel_req = in_valid[i];
    end
  end

`ifdef MUX_ARB_LOCK_EN
  lock_state_e     lock_state_q, lock_state_d;
  logic [SELW-1:0] lock_idx_q, lock_idx_d;
  logic            locked;
  logic            lock_req;
  logic            cand_lock;

  // Request and lock flag of the locked channel / current candidate.
  always_comb begin
    lock_req  = 1'b0;
    cand_lock = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (lock_idx_q == SELW'(i)) lock_req  = in_valid[i];
      if (cand_idx == SELW'(i))   cand_lock = in_lock[i];
    end
  end

  // Candidate selection; a held lock overrides mode and sel.
  always_comb begin
    if (locked) begin
      cand_valid = lock_req;
      cand_idx   = lock_idx_q;
    end else if (mode == MODE_RR) begin
      cand_valid = rr_any;
      cand_idx   = rr_idx;
    end else begin
      cand_valid = sel_req;
      cand_idx   = sel;
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_state_q <= ST_IDLE;
      lock_idx_q   <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_idx_q   <= lock_idx_d;
    end
  end

  // Lock FSM next state: enter on a locked transfer, leave on an unlocked one from the owner.
  always_comb begin
    lock_state_d = lock_state_q;
    lock_idx_d   = lock_idx_q;
    case (lock_state_q)
      ST_IDLE: begin
        if (grant_valid && cand_lock) begin
          lock_state_d = ST_LOCKED;
          lock_idx_d   = cand_idx;
        end
      end
      ST_LOCKED: begin
        if (grant_valid && !cand_lock) lock_state_d = ST_IDLE;
      end
      default: lock_state_d = ST_IDLE;
    endcase
  end

  // Lock FSM output decode.
  always_comb begin
    locked = (lock_state_q == ST_LOCKED);
  end
`else
  // Candidate selection by mode.
  always_comb begin
    if (mode == MODE_RR) begin
      cand_valid = rr_any;
      cand_idx   = rr_idx;
    end else begin
      cand_valid = sel_req;
      cand_idx   = sel;
    end
  end
`endif

  // Grant only into a free slot and never while reset is asserted.
  assign grant_valid = rst_n && slot_free && cand_valid;

  // One-hot accept to the granted channel and its data word.
  always_comb begin
    in_ready  = '0;
    cand_data = '0;
    for (int i = 0; i < N; i++) begin
      if (cand_idx == SELW'(i)) begin
        in_ready[i] = grant_valid;
        cand_data   = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output slot and round-robin pointer next state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (slot_free) begin
      out_valid_d = grant_valid;
      if (grant_valid) begin
        out_data_d = cand_data;
        out_src_d  = cand_idx;
      end
    end
    if (grant_valid && mode == MODE_RR) rr_ptr_d = cand_idx;
  end

  // Output register; reset points rr_ptr at N-1 so the first search begins at channel 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= SELW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
